// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, ALUOp and PCSrc constants plus the control bundle.
// Optional feature macro: CTRL_BRANCH_EN (beq/j resolved in ID).
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
   } ctrl_t;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
   } mem_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Opcode-to-bundle link between the control top and the ID decoder.
// Optional feature macro: CTRL_BRANCH_EN.
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic [5:0] op;
   ctrl_t      ctrl;
   logic       illegal;
   logic       rd_rt;

   modport master (output op, input ctrl, input illegal, input rd_rt);
   modport slave  (input op, output ctrl, output illegal, output rd_rt);

endinterface

// File: rtl/pipe_ctrl_dec.sv
// Pure opcode decoder: control bundle, illegal flag, reads-rt flag.
// Optional feature macro: CTRL_BRANCH_EN adds beq and j.
module pipe_ctrl_dec
   import pipe_ctrl_pkg::*;
(
   pipe_ctrl_if.slave dec
);

   // Opcode to control bundle; unknown opcodes become an all-zero NOP
   always_comb begin
      dec.ctrl    = '0;
      dec.illegal = 1'b0;
      unique case (1'b1)
         (dec.op == OP_RTYPE): dec.ctrl = '{1'b1, 1'b0, ALUOP_FUNCT,
                                           1'b0, 1'b0, 1'b1, 1'b0};
         (dec.op == OP_ADDI):  dec.ctrl = '{1'b0, 1'b1, ALUOP_ADD,
                                           1'b0, 1'b0, 1'b1, 1'b0};
         (dec.op == OP_LW):    dec.ctrl = '{1'b0, 1'b1, ALUOP_ADD,
                                           1'b1, 1'b0, 1'b1, 1'b1};
         (dec.op == OP_SW):    dec.ctrl = '{1'b0, 1'b1, ALUOP_ADD,
                                           1'b0, 1'b1, 1'b0, 1'b0};
`ifdef CTRL_BRANCH_EN
         (dec.op == OP_BEQ):   dec.ctrl = '{1'b0, 1'b0, ALUOP_SUB,
                                           1'b0, 1'b0, 1'b0, 1'b0};
         (dec.op == OP_J):     dec.ctrl = '0;
`endif
         default:              dec.illegal = 1'b1;
      endcase
   end

   // Opcodes whose rt field is a source operand
   always_comb begin
      dec.rd_rt = (dec.op == OP_RTYPE) || (dec.op == OP_SW)
               || (dec.op == OP_BEQ);
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined main control: decode, load-use bubbles, stage registers.
// Optional feature macro: CTRL_BRANCH_EN resolves beq/j in ID.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [5:0]        Op_i,
   input  logic [REG_AW-1:0] IdRs_i,
   input  logic [REG_AW-1:0] IdRt_i,
   input  logic [REG_AW-1:0] ExRt_i,
   input  logic              BrEq_i,
   output logic              PCWrite_o,
   output logic              IFIDWrite_o,
   output logic              Stall_o,
   output logic              Flush_o,
   output logic [1:0]        PCSrc_o,
   output logic              Ex_RegDst_o,
   output logic              Ex_ALUSrc_o,
   output logic [1:0]        Ex_ALUOp_o,
   output logic              Mem_MemRead_o,
   output logic              Mem_MemWrite_o,
   output logic              Wb_RegWrite_o,
   output logic              Wb_MemtoReg_o,
   output logic [CNT_W-1:0]  IllegalCnt_o
);

   pipe_ctrl_if dbus ();

   assign dbus.op = Op_i;

   pipe_ctrl_dec u_dec (
      .dec (dbus.slave)
   );

   ctrl_t            ex_q;
   mem_ctrl_t        mem_q;
   wb_ctrl_t         wb_q;
   ctrl_t            ex_d;
   logic             hazard;
   logic [CNT_W-1:0] cnt_q;

   // Load-use: the load in EX writes a register the ID instruction reads
   always_comb begin
      hazard = ex_q.mem_read && (ExRt_i != '0)
            && ((ExRt_i == IdRs_i)
             || ((ExRt_i == IdRt_i) && dbus.rd_rt));
      ex_d   = hazard ? ctrl_t'('0) : dbus.ctrl;
   end

   assign Stall_o     = hazard;
   assign PCWrite_o   = !hazard;
   assign IFIDWrite_o = !hazard;

`ifdef CTRL_BRANCH_EN
   // Redirect in ID; a coinciding stall defers it to the re-decode
   always_comb begin
      Flush_o = 1'b0;
      PCSrc_o = PCSRC_SEQ;
      if (!hazard) begin
         if (Op_i == OP_J) begin
            Flush_o = 1'b1;
            PCSrc_o = PCSRC_JMP;
         end else if (Op_i == OP_BEQ && BrEq_i) begin
            Flush_o = 1'b1;
            PCSrc_o = PCSRC_BR;
         end
      end
   end
`else
   logic unused_br_eq;
   assign unused_br_eq = BrEq_i;
   assign Flush_o      = 1'b0;
   assign PCSrc_o      = PCSRC_SEQ;
`endif

   // Stage registers load every edge; stalls are handled at IF/ID
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= '{ex_q.mem_read, ex_q.mem_write,
                    ex_q.reg_write, ex_q.mem_to_reg};
         wb_q  <= '{mem_q.reg_write, mem_q.mem_to_reg};
      end
   end

   // Saturating count of illegal opcodes entering ID/EX
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else if (dbus.illegal && !hazard && cnt_q != '1) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign Ex_RegDst_o    = ex_q.reg_dst;
   assign Ex_ALUSrc_o    = ex_q.alu_src;
   assign Ex_ALUOp_o     = ex_q.alu_op;
   assign Mem_MemRead_o  = mem_q.mem_read;
   assign Mem_MemWrite_o = mem_q.mem_write;
   assign Wb_RegWrite_o  = wb_q.reg_write;
   assign Wb_MemtoReg_o  = wb_q.mem_to_reg;
   assign IllegalCnt_o   = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with hand-computed expectations.
// Branch checks are compiled in with CTRL_BRANCH_EN.
module tb_pipe_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [4:0] IdRs_i, IdRt_i, ExRt_i;
   logic       BrEq_i;
   logic       PCWrite_o, IFIDWrite_o, Stall_o, Flush_o;
   logic [1:0] PCSrc_o, Ex_ALUOp_o;
   logic       Ex_RegDst_o, Ex_ALUSrc_o;
   logic       Mem_MemRead_o, Mem_MemWrite_o;
   logic       Wb_RegWrite_o, Wb_MemtoReg_o;
   logic [7:0] IllegalCnt_o;

   int checks = 0;
   int errors = 0;

   pipe_ctrl_if bus ();

   assign bus.ctrl    = '0;
   assign bus.illegal = 1'b0;
   assign bus.rd_rt   = 1'b0;

   always #5 clk_i = ~clk_i;

   pipe_ctrl #(.CNT_W(8), .REG_AW(5)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .Op_i           (bus.op),
      .IdRs_i         (IdRs_i),
      .IdRt_i         (IdRt_i),
      .ExRt_i         (ExRt_i),
      .BrEq_i         (BrEq_i),
      .PCWrite_o      (PCWrite_o),
      .IFIDWrite_o    (IFIDWrite_o),
      .Stall_o        (Stall_o),
      .Flush_o        (Flush_o),
      .PCSrc_o        (PCSrc_o),
      .Ex_RegDst_o    (Ex_RegDst_o),
      .Ex_ALUSrc_o    (Ex_ALUSrc_o),
      .Ex_ALUOp_o     (Ex_ALUOp_o),
      .Mem_MemRead_o  (Mem_MemRead_o),
      .Mem_MemWrite_o (Mem_MemWrite_o),
      .Wb_RegWrite_o  (Wb_RegWrite_o),
      .Wb_MemtoReg_o  (Wb_MemtoReg_o),
      .IllegalCnt_o   (IllegalCnt_o)
   );

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic drv(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                      logic [4:0] ert, logic beq);
      bus.op = op;
      IdRs_i = rs;
      IdRt_i = rt;
      ExRt_i = ert;
      BrEq_i = beq;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   localparam logic [5:0] R  = 6'b000000;
   localparam logic [5:0] AI = 6'b001000;
   localparam logic [5:0] LW = 6'b100011;
   localparam logic [5:0] SW = 6'b101011;
   localparam logic [5:0] BQ = 6'b000100;
   localparam logic [5:0] JJ = 6'b000010;
   localparam logic [5:0] XX = 6'b111111;

   initial begin
      rst_i = 1'b0;
      drv(LW, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      tick();
      chk("rst_ex_alusrc", Ex_ALUSrc_o, 0);
      chk("rst_mem_rd", Mem_MemRead_o, 0);
      chk("rst_wb_rw", Wb_RegWrite_o, 0);
      chk("rst_cnt", IllegalCnt_o, 0);
      chk("rst_pcwrite", PCWrite_o, 1);
      chk("rst_stall", Stall_o, 0);
      chk("rst_flush", Flush_o, 0);
      chk("rst_pcsrc", PCSrc_o, 0);
      rst_i = 1'b1;

      // staging: lw, addi, R
      drv(LW, 5'd1, 5'd2, 5'd0, 1'b0);
      tick();
      chk("stg_ex_alusrc", Ex_ALUSrc_o, 1);
      chk("stg_ex_regdst", Ex_RegDst_o, 0);
      drv(AI, 5'd3, 5'd4, 5'd2, 1'b0);
      chk("stg_nostall", Stall_o, 0);
      tick();
      chk("stg_mem_rd", Mem_MemRead_o, 1);
      drv(R, 5'd5, 5'd6, 5'd4, 1'b0);
      tick();
      chk("stg_wb_m2r", Wb_MemtoReg_o, 1);
      chk("stg_wb_rw", Wb_RegWrite_o, 1);
      chk("stg_mem_rd0", Mem_MemRead_o, 0);
      chk("stg_ex_aluop", Ex_ALUOp_o, 2);

      // load-use on rs
      drv(LW, 5'd1, 5'd8, 5'd6, 1'b0);
      tick();
      drv(R, 5'd8, 5'd1, 5'd8, 1'b0);
      chk("lu_stall", Stall_o, 1);
      chk("lu_pcwrite", PCWrite_o, 0);
      chk("lu_ifidwrite", IFIDWrite_o, 0);
      tick();
      chk("lu_bub_regdst", Ex_RegDst_o, 0);
      chk("lu_bub_aluop", Ex_ALUOp_o, 0);
      chk("lu_one_cycle", Stall_o, 0);
      chk("lu_pcwrite1", PCWrite_o, 1);
      tick();
      chk("lu_redec", Ex_RegDst_o, 1);

      // ExRt = 0 never stalls
      drv(LW, 5'd1, 5'd0, 5'd1, 1'b0);
      tick();
      drv(R, 5'd0, 5'd0, 5'd0, 1'b0);
      chk("lu_zero", Stall_o, 0);

      // sw reads rt, addi does not
      drv(LW, 5'd1, 5'd9, 5'd0, 1'b0);
      tick();
      drv(SW, 5'd1, 5'd9, 5'd9, 1'b0);
      chk("lu_sw", Stall_o, 1);
      tick();
      drv(LW, 5'd1, 5'd9, 5'd0, 1'b0);
      tick();
      drv(AI, 5'd1, 5'd9, 5'd9, 1'b0);
      chk("lu_addi", Stall_o, 0);
      chk("cnt_legal", IllegalCnt_o, 0);
      tick();

      // illegal opcode counting and saturation
      drv(XX, 5'd0, 5'd0, 5'd0, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      chk("ill_cnt10", IllegalCnt_o, 10);
      chk("ill_memwr", Mem_MemWrite_o, 0);
      chk("ill_wbrw", Wb_RegWrite_o, 0);
      for (int i = 0; i < 290; i++) tick();
      chk("ill_sat", IllegalCnt_o, 255);
      chk("ill_wbrw2", Wb_RegWrite_o, 0);

      // asynchronous reset mid-cycle
      #2;
      rst_i = 1'b0;
      #1;
      chk("arst_cnt", IllegalCnt_o, 0);
      drv(AI, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      chk("arst_ex", Ex_ALUSrc_o, 0);
      rst_i = 1'b1;

      // j: illegal unless branches are built in
      drv(JJ, 5'd0, 5'd0, 5'd0, 1'b0);
`ifdef CTRL_BRANCH_EN
      chk("j_pcsrc", PCSrc_o, 2);
      chk("j_flush", Flush_o, 1);
      tick();
      chk("j_cnt", IllegalCnt_o, 0);

      drv(BQ, 5'd1, 5'd2, 5'd0, 1'b1);
      chk("beq_pcsrc", PCSrc_o, 1);
      chk("beq_flush", Flush_o, 1);
      tick();
      chk("beq_aluop", Ex_ALUOp_o, 1);
      drv(BQ, 5'd1, 5'd2, 5'd0, 1'b0);
      chk("beqn_flush", Flush_o, 0);
      chk("beqn_pcsrc", PCSrc_o, 0);
      tick();

      drv(LW, 5'd1, 5'd7, 5'd0, 1'b0);
      tick();
      drv(BQ, 5'd7, 5'd3, 5'd7, 1'b1);
      chk("beqs_stall", Stall_o, 1);
      chk("beqs_flush", Flush_o, 0);
      chk("beqs_pcsrc", PCSrc_o, 0);
      tick();
      chk("beqs_flush1", Flush_o, 1);
      chk("beqs_pcsrc1", PCSrc_o, 1);
      chk("beqs_cnt", IllegalCnt_o, 0);
`else
      chk("j_pcsrc", PCSrc_o, 0);
      chk("j_flush", Flush_o, 0);
      tick();
      chk("j_cnt", IllegalCnt_o, 1);
      drv(BQ, 5'd1, 5'd2, 5'd0, 1'b1);
      chk("beq_flush", Flush_o, 0);
      tick();
      chk("beq_cnt", IllegalCnt_o, 2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipelined main control unit for the 5-stage MIPS core. It decodes the opcode in ID into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers, so each stage sees its own slice. It also detects load-use hazards and inserts bubbles, decodes illegal opcodes into safe NOPs and counts them. With branch support compiled in, it resolves beq/j in ID and flushes IF/ID. It sits between the IF/ID register and the datapath's stage muxes, ALU control and data memory.

## Interface
Parameters:
- CNT_W, 8: width of the illegal-opcode counter.
- REG_AW, 5: register address width.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- Op_i  in  6  opcode of the instruction in ID (inst[31:26]).
- IdRs_i  in  REG_AW  rs field of the instruction in ID.
- IdRt_i  in  REG_AW  rt field of the instruction in ID.
- ExRt_i  in  REG_AW  rt field held in ID/EX by the datapath.
- BrEq_i  in  1  ID register comparator result (rs == rt). Used only with CTRL_BRANCH_EN.
- PCWrite_o  out  1  0 freezes the PC.
- IFIDWrite_o  out  1  0 freezes IF/ID.
- Stall_o  out  1  load-use stall this cycle.
- Flush_o  out  1  clear IF/ID on the next edge.
- PCSrc_o  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- Ex_RegDst_o, Ex_ALUSrc_o  out  1 each  EX-stage controls.
- Ex_ALUOp_o  out  2  EX-stage ALU op class.
- Mem_MemRead_o, Mem_MemWrite_o  out  1 each  MEM-stage controls.
- Wb_RegWrite_o, Wb_MemtoReg_o  out  1 each  WB-stage controls.
- IllegalCnt_o  out  CNT_W  saturating count of illegal opcodes that reached ID/EX.

## Operation
Decode (combinational). Bundle order is {RegDst, ALUSrc, ALUOp, MemRead, MemWrite, RegWrite, MemtoReg}.
- R-type 000000 → {1,0,10,0,0,1,0}.
- addi 001000 → {0,1,00,0,0,1,0}.
- lw 100011 → {0,1,00,1,0,1,1}.
- sw 101011 → {0,1,00,0,1,0,0}.
- Any other opcode is illegal. Its bundle is all-zero, so it writes no register and no memory.

Load-use hazard (combinational):
- Raised when ID/EX MemRead = 1, ExRt_i != 0, and either:
  - ExRt_i == IdRs_i, or
  - ExRt_i == IdRt_i and the ID opcode reads rt (R-type, sw, beq).
- While raised: Stall_o = 1, PCWrite_o = 0, IFIDWrite_o = 0, and the bundle entering ID/EX is forced all-zero (a bubble).

Pipeline registers:
- ID/EX loads the decoded bundle, or a bubble, on every edge.
- EX/MEM loads the MEM and WB fields from ID/EX.
- MEM/WB loads the WB fields from EX/MEM.
- None of these registers has an enable. The datapath handles stalls through IF/ID only.

Illegal counter:
- Increments when an illegal opcode is loaded into ID/EX. A stalled or bubbled cycle does not count.
- Saturates at 2^CNT_W − 1; it does not wrap.

## Timing
- Reset (rst_i low, asynchronous) clears every pipeline register and the counter. While rst_i is low, all Ex_/Mem_/Wb_ outputs and IllegalCnt_o read 0.
- After reset: PCWrite_o = IFIDWrite_o = 1; Stall_o = Flush_o = 0; PCSrc_o = 00.
- Releasing reset mid-stream needs no special handling: the pipeline contents are bubbles.
- An instruction in ID in cycle n drives Ex_* in cycle n+1, Mem_* in cycle n+2 and Wb_* in cycle n+3.
- A load-use stall lasts exactly one cycle, because the bubble clears the MemRead condition.
- If the stall condition and a branch/jump occur in the same cycle, the stall wins. Flush_o = 0 and PCSrc_o = 00 that cycle, and the branch is re-decoded the following cycle.

## Configuration
Macro `CTRL_BRANCH_EN`:
- Defined:
  - beq (000100) → {0,0,01,0,0,0,0}; if BrEq_i = 1, then PCSrc_o = 01 and Flush_o = 1.
  - j (000010) → all-zero bundle, PCSrc_o = 10, Flush_o = 1.
  - Neither opcode counts as illegal.
- Undefined:
  - Both opcodes are illegal.
  - Flush_o is tied to 0 and PCSrc_o to 00.
  - BrEq_i is ignored.

## Structure
- Package pipe_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J);
  - ALUOp constants (ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10);
  - PCSrc constants;
  - the packed control-bundle typedef.
- Sub-module pipe_ctrl_dec is the pure opcode decoder. It outputs the bundle and an illegal flag.
- The hazard logic, pipeline registers and counter stay in pipe_ctrl.

## Test plan
- Reset: hold rst_i low, then drive Op_i = 100011 → all stage outputs 0, IllegalCnt_o = 0, PCWrite_o = 1. The counter is 0 throughout.
- Stage staging: lw at cycle 1 → Ex_ALUSrc_o = 1 at cycle 2, Mem_MemRead_o = 1 at cycle 3, Wb_MemtoReg_o = Wb_RegWrite_o = 1 at cycle 4.
- Load-use: lw with ExRt_i = 8, followed by R-type with IdRs_i = 8 → one cycle of Stall_o = 1, PCWrite_o = IFIDWrite_o = 0, bubble in the Ex_ outputs. Repeat with ExRt_i = 0 → no stall.
- sw after lw with IdRt_i == ExRt_i = 9 → stall. addi after lw with IdRt_i == ExRt_i = 9 → no stall.
- Illegal: feed opcode 111111 for 300 cycles with CNT_W = 8 → IllegalCnt_o saturates at 255; Mem_MemWrite_o and Wb_RegWrite_o stay 0.
- With `CTRL_BRANCH_EN`:
  - beq with BrEq_i = 1 → PCSrc_o = 01, Flush_o = 1.
  - beq with BrEq_i = 0 → no flush.
  - j → PCSrc_o = 10.
  - beq coinciding with a load-use stall → no flush that cycle, then taken the next cycle.
